// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider.
// Issues div/divu, stalls until done, writes HI/LO.
module div_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        ex_stall_in,
    input  logic        flush,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        div_start,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          go;
    logic          issue;
    logic          zero_op;

    assign go      = ex_div_valid & ~flush;
    assign issue   = go & (ex_b != 32'd0);
    assign zero_op = go & (ex_b == 32'd0);

    // Stall drops in the done cycle so EX advances with the write.
    always_comb begin
        stall_req = 1'b0;
        case (state)
            IDLE:    stall_req = issue;
            RUN:     stall_req = ~div_done;
            default: stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            div_start <= 1'b0;
            div_sign  <= 1'b0;
            div_a     <= 32'd0;
            div_b     <= 32'd0;
            hilo_we   <= 1'b0;
            hi_out    <= 32'd0;
            lo_out    <= 32'd0;
            div_err   <= 1'b0;
        end else begin
            hilo_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= RUN;
                        cnt       <= '0;
                        div_start <= 1'b1;
                        div_sign  <= ex_div_signed;
                        div_a     <= ex_a;
                        div_b     <= ex_b;
                    end else if (zero_op) begin
                        state   <= HOLD;
                        hilo_we <= 1'b1;
                        hi_out  <= ex_a;
                        lo_out  <= 32'hFFFF_FFFF;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (flush) begin
                        state     <= IDLE;
                        div_start <= 1'b0;
                    end else if (div_done) begin
                        state     <= HOLD;
                        div_start <= 1'b0;
                        hilo_we   <= 1'b1;
                        hi_out    <= div_remainder;
                        lo_out    <= div_quotient;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Hung divider: abort like a flush and flag it.
                        state     <= IDLE;
                        div_start <= 1'b0;
                        div_err   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || !ex_stall_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
